// File: rtl/lu_or_nor_sequencer_if.sv
// Request/operand/result bundle for the serial OR/NOR sequencer.
// Two requesters share one bit-serial logic unit.
interface lu_or_nor_sequencer_if #(
  parameter int WIDTH = 4
);
  logic             req0;
  logic             req1;
  logic             op0;
  logic             op1;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             gnt0;
  logic             gnt1;
  logic             busy;
  logic             done;
  logic             owner;
  logic [WIDTH-1:0] result;

  modport master (
    output req0, req1, op0, op1,
    output a0, b0, a1, b1,
    input  gnt0, gnt1, busy, done,
    input  owner, result
  );

  modport slave (
    input  req0, req1, op0, op1,
    input  a0, b0, a1, b1,
    output gnt0, gnt1, busy, done,
    output owner, result
  );
endinterface

// File: rtl/lu_or_nor_sequencer.sv
// Round-robin two-requester sequencer feeding one 1-bit OR/NOR unit.
// Operands are processed LSB first; result is published on DONE.
module lu_or_nor_sequencer #(
  parameter int WIDTH = 4
) (
  input logic                  clk,
  input logic                  reset,
  lu_or_nor_sequencer_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BIT,
    DONE
  } state_t;

  state_t           state, state_n;
  logic             gnt0, gnt0_n;
  logic             gnt1, gnt1_n;
  logic             busy, busy_n;
  logic             done, done_n;
  logic             owner, owner_n;
  logic             prio, prio_n;
  logic             op, op_n;
  logic [WIDTH-1:0] a, a_n;
  logic [WIDTH-1:0] b, b_n;
  logic [WIDTH-1:0] sh, sh_n;
  logic [WIDTH-1:0] result, result_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             win;
  logic             lu_bit;

  // The one and only logic unit.
  assign lu_bit = op ? ~(a[cnt] | b[cnt]) : (a[cnt] | b[cnt]);

  always_comb begin
    state_n  = state;
    gnt0_n   = 1'b0;
    gnt1_n   = 1'b0;
    busy_n   = busy;
    done_n   = 1'b0;
    owner_n  = owner;
    prio_n   = prio;
    op_n     = op;
    a_n      = a;
    b_n      = b;
    sh_n     = sh;
    result_n = result;
    cnt_n    = cnt;
    win      = (bus.req0 && bus.req1) ? prio : bus.req1;
    unique case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (bus.req0 || bus.req1) begin
          state_n = BIT;
          gnt0_n  = ~win;
          gnt1_n  = win;
          busy_n  = 1'b1;
          owner_n = win;
          prio_n  = ~win;
          op_n    = win ? bus.op1 : bus.op0;
          a_n     = win ? bus.a1 : bus.a0;
          b_n     = win ? bus.b1 : bus.b0;
          sh_n    = '0;
          cnt_n   = '0;
        end
      end
      BIT: begin
        sh_n  = {lu_bit, sh[WIDTH-1:1]};
        cnt_n = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          state_n  = DONE;
          result_n = {lu_bit, sh[WIDTH-1:1]};
          done_n   = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  // prio resets to 0 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      owner  <= 1'b0;
      prio   <= 1'b0;
      op     <= 1'b0;
      a      <= '0;
      b      <= '0;
      sh     <= '0;
      result <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_n;
      gnt0   <= gnt0_n;
      gnt1   <= gnt1_n;
      busy   <= busy_n;
      done   <= done_n;
      owner  <= owner_n;
      prio   <= prio_n;
      op     <= op_n;
      a      <= a_n;
      b      <= b_n;
      sh     <= sh_n;
      result <= result_n;
      cnt    <= cnt_n;
    end
  end

  assign bus.gnt0   = gnt0;
  assign bus.gnt1   = gnt1;
  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.owner  = owner;
  assign bus.result = result;
endmodule

// File: tb/tb_lu_or_nor_sequencer.sv
// Bench for lu_or_nor_sequencer: directed cases, random traffic,
// and an exhaustive operand sweep against a whole-word model.
module tb_lu_or_nor_sequencer;
  localparam int W = 4;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  bit   pref;

  lu_or_nor_sequencer_if #(.WIDTH(W)) bus ();

  lu_or_nor_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    pref  = 1'b0;
  endtask

  // Wait for a grant, then follow the operation to completion.
  task automatic serve(input bit drop, input bit mutate,
                       output int gwait);
    logic         ew;
    logic         eop;
    logic [W-1:0] ea;
    logic [W-1:0] eb;
    logic [W-1:0] er;
    int           n;
    ew  = (bus.req0 && bus.req1) ? pref : bus.req1;
    eop = ew ? bus.op1 : bus.op0;
    ea  = ew ? bus.a1 : bus.a0;
    eb  = ew ? bus.b1 : bus.b0;
    er  = eop ? ~(ea | eb) : (ea | eb);
    gwait = 0;
    do begin
      tick();
      gwait++;
    end while (!(bus.gnt0 || bus.gnt1) && gwait < 20);
    chk("gnt_seen", 32'(bus.gnt0 | bus.gnt1), 1);
    chk("gnt_excl", 32'(bus.gnt0 & bus.gnt1), 0);
    chk("gnt_who", 32'(bus.gnt1), 32'(ew));
    chk("busy_grant", 32'(bus.busy), 1);
    pref = ~ew;
    if (drop) idle_inputs();
    if (mutate) begin
      bus.a0  = ~bus.a0;
      bus.b0  = ~bus.b0;
      bus.op0 = ~bus.op0;
      bus.a1  = ~bus.a1;
      bus.b1  = ~bus.b1;
      bus.op1 = ~bus.op1;
    end
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) chk("gnt_pulse", 32'(bus.gnt0 | bus.gnt1), 0);
    end while (!bus.done && n < 3 * W);
    chk("latency", n, W);
    chk("result", 32'(bus.result), 32'(er));
    chk("owner", 32'(bus.owner), 32'(ew));
    chk("busy_done", 32'(bus.busy), 1);
    tick();
    chk("done_pulse", 32'(bus.done), 0);
    chk("busy_idle", 32'(bus.busy), 0);
  endtask

  initial begin
    int g;
    int dseen;
    vectors     = 0;
    miscompares = 0;
    pref        = 1'b0;
    reset       = 1'b1;
    idle_inputs();
    bus.op0 = 1'b0;
    bus.op1 = 1'b0;
    bus.a0  = '0;
    bus.b0  = '0;
    bus.a1  = '0;
    bus.b1  = '0;
    #1;
    chk("rst_gnt0", 32'(bus.gnt0), 0);
    chk("rst_gnt1", 32'(bus.gnt1), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_owner", 32'(bus.owner), 0);
    chk("rst_result", 32'(bus.result), 0);
    do_reset();

    // Requester 0 OR, then requester 1 NOR.
    bus.req0 = 1'b1;
    bus.op0  = 1'b0;
    bus.a0   = 4'b0101;
    bus.b0   = 4'b0011;
    serve(1'b1, 1'b0, g);
    chk("r30_result", 32'(bus.result), 32'h7);
    bus.req1 = 1'b1;
    bus.op1  = 1'b1;
    bus.a1   = 4'b1100;
    bus.b1   = 4'b1010;
    serve(1'b1, 1'b0, g);
    chk("r31_result", 32'(bus.result), 32'h1);

    // Both held from reset: strict alternation, W+2 cycles apart.
    do_reset();
    bus.op0  = 1'b0;
    bus.op1  = 1'b0;
    bus.a0   = 4'b0001;
    bus.b0   = 4'b0000;
    bus.a1   = 4'b1000;
    bus.b1   = 4'b0000;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      serve(1'b0, 1'b0, g);
      chk("rr_order", 32'(bus.owner), i % 2);
      chk("rr_result", 32'(bus.result), (i % 2) ? 32'h8 : 32'h1);
      if (i > 0) chk("b2b_wait", g, 1);
    end
    idle_inputs();
    tick();

    // Operand change after grant must not leak in.
    bus.req0 = 1'b1;
    bus.op0  = 1'b0;
    bus.a0   = 4'b0000;
    bus.b0   = 4'b0010;
    serve(1'b1, 1'b1, g);
    chk("r33_result", 32'(bus.result), 32'h2);

    // Abort by reset two cycles after grant.
    bus.req0 = 1'b1;
    bus.a0   = 4'b0110;
    bus.b0   = 4'b0000;
    g = 0;
    do begin
      tick();
      g++;
    end while (!bus.gnt0 && g < 20);
    chk("abort_gnt", 32'(bus.gnt0), 1);
    idle_inputs();
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_result", 32'(bus.result), 0);
    chk("abort_owner", 32'(bus.owner), 0);
    dseen = 0;
    tick();
    dseen += int'(bus.done);
    reset = 1'b0;
    pref  = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      tick();
      dseen += int'(bus.done);
    end
    chk("abort_nodone", dseen, 0);
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    serve(1'b1, 1'b0, g);
    chk("abort_first", 32'(bus.owner), 0);

    // Random traffic.
    for (int i = 0; i < 60; i++) begin
      int r;
      r = $urandom_range(1, 3);
      bus.req0 = r[0];
      bus.req1 = r[1];
      bus.op0  = 1'($urandom);
      bus.op1  = 1'($urandom);
      bus.a0   = W'($urandom);
      bus.b0   = W'($urandom);
      bus.a1   = W'($urandom);
      bus.b1   = W'($urandom);
      serve(1'b1, 1'($urandom), g);
    end

    // Exhaustive sweep on requester 0.
    for (int op = 0; op < 2; op++) begin
      for (int v = 0; v < (1 << (2 * W)); v++) begin
        bus.req0 = 1'b1;
        bus.req1 = 1'b0;
        bus.op0  = 1'(op);
        bus.a0   = W'(v);
        bus.b0   = W'(v >> W);
        serve(1'b1, 1'b0, g);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
